serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the team's 1-bit full adder (FA). It accepts two operands and a carry-in through a start handshake, then feeds FA one bit pair per clock, LSB first. A registered carry loops back into FA's carry input each cycle. After WIDTH cycles it presents the full sum and carry-out with a one-cycle done pulse, for area-constrained datapaths upstream of result consumers.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range is 1 to 32.
- iClk  input  1  clock; everything is updated on the rising edge.
- iRst  input  1  reset; synchronous, active-high.
- iStart  input  1  request to begin an addition; sampled each rising edge.
- iA  input  WIDTH  operand A; captured only when a start is accepted.
- iB  input  WIDTH  operand B; captured only when a start is accepted.
- iCin  input  1  carry-in; captured only when a start is accepted.
- oBusy  output  1  high while an addition is in progress (state RUN).
- oDone  output  1  one-cycle pulse marking oSum/oCout valid (state DONE).
- oSum  output  WIDTH  result register.
- oCout  output  1  final carry-out.

## Operation
- States:
  - IDLE, RUN, DONE.
  - Encodings: 2'b00, 2'b01, 2'b10.
- Reset (iRst high at an edge):
  - state goes to IDLE.
  - Bit counter, carry flop, operand shift registers, oSum and oCout all clear to 0.
  - oBusy=0 and oDone=0.
  - Reset takes priority over every other input, including in the middle of RUN; a partial result is discarded.
- IDLE or DONE with iStart=1:
  - load iA and iB into the shift registers.
  - carry flop <= iCin; counter <= 0; oSum <= 0.
  - state goes to RUN.
- IDLE or DONE with iStart=0: IDLE holds; DONE moves to IDLE.
- RUN, on every edge:
  - FA is driven with iA=A_sr[0], iB=B_sr[0], iC=carry.
  - FA's oS is shifted into oSum from the MSB end: oSum <= {oS, oSum[WIDTH-1:1]}.
  - carry <= FA oC.
  - A_sr and B_sr shift right by one, filling with 0.
  - counter increments.
- RUN exit: on the edge that processes bit WIDTH-1 (counter == WIDTH-1), state goes to DONE and oCout <= FA oC.
- iStart during RUN is ignored; operands already captured are unaffected.
- Inputs iA, iB and iCin may change freely except at the edge where a start is accepted.
- oSum and oCout hold their values from DONE through IDLE until the next accepted start clears oSum.
- Arithmetic:
  - {oCout, oSum} = iA + iB + iCin, taken modulo 2^(WIDTH+1).
  - The counter is $clog2(WIDTH)+1 bits wide so it never wraps.

## Timing
- Start accepted at edge k: oBusy is high from after edge k through after edge k+WIDTH-1.
- Edge k+WIDTH: state goes to DONE; oDone=1 and oBusy=0 for exactly one cycle.
- Result valid: oSum and oCout are valid in the cycle after edge k+WIDTH.
- Latency: WIDTH+1 edges from start to valid result.
- Throughput: one addition every WIDTH+1 cycles. This is achieved by asserting iStart during the DONE cycle.
- oBusy and oDone are decoded directly from the state register; they have no combinational path from inputs.
- WIDTH=1: RUN lasts exactly one edge.

## Structure
- Shared package serial_adder_pkg holds:
  - the state encodings IDLE, RUN and DONE as localparams;
  - the WIDTH default.
- Exactly one sub-module: the existing 1-bit full adder FA, instantiated once.
- Everything else is the top level: the FSM, counter, carry flop and three shift registers.

## Test plan
All scenarios use WIDTH=8.
- Basic add, no carry: iA=0x5A, iB=0x3C, iCin=0, start -> oDone after 9 edges; oSum=0x96, oCout=0; oBusy high for 8 cycles.
- Full ripple: iA=0xFF, iB=0x01, iCin=0 -> oSum=0x00, oCout=1.
- Maximum operands: iA=0xFF, iB=0xFF, iCin=1 -> oSum=0xFF, oCout=1.
- Start ignored while busy: start 0x12+0x34, then pulse iStart with 0xFF/0xFF at RUN cycle 3 -> result stays oSum=0x46, oCout=0; exactly one oDone pulse.
- Reset mid-operation: start 0xAA+0x55, assert iRst at RUN cycle 4 -> next cycle state IDLE, oBusy=0, oSum=0, oCout=0, and no oDone follows. A subsequent 0x01+0x01 gives 0x02.
- Back-to-back: assert iStart in the DONE cycle with 0x80+0x80, iCin=0 -> first oDone still lasts one cycle; second result is oSum=0x00, oCout=1, 9 edges later.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder: the FSM state encodings
// and the default operand width. Both the top level and the bench pull
// these in with import serial_adder_pkg::*.
package serial_adder_pkg;

    // Default operand/sum width. Legal range is 1 to 32.
    localparam int WIDTH_DEFAULT = 8;

    // State encodings. Downstream debug tools decode the raw state
    // register, so these values are fixed.
    localparam logic [1:0] IDLE_CODE = 2'b00;
    localparam logic [1:0] RUN_CODE  = 2'b01;
    localparam logic [1:0] DONE_CODE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = IDLE_CODE,
        RUN  = RUN_CODE,
        DONE = DONE_CODE
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// FA
// The team's 1-bit full adder. This is pure combinational logic.
// Ports:
//   iA, iB : input  - addend bits
//   iC     : input  - carry in
//   oS     : output - sum bit
//   oC     : output - carry out
module FA (
    input  logic iA,
    input  logic iB,
    input  logic iC,
    output logic oS,
    output logic oC
);

    assign oS = iA ^ iB ^ iC;
    assign oC = (iA & iB) | (iC & (iA ^ iB));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// This is a bit-serial WIDTH-bit adder built around a single FA.
// After a start is accepted, the adder processes one bit pair per clock,
// starting with the least significant bit. A registered carry loops back
// into the FA. After WIDTH cycles, the full sum and carry-out are
// presented, together with a one-cycle done pulse.
// Ports:
//   iClk   : input  - clock, rising edge
//   iRst   : input  - synchronous active-high reset
//   iStart : input  - start request (ignored while busy)
//   iA, iB : input  - operands, captured on an accepted start
//   iCin   : input  - carry-in, captured on an accepted start
//   oBusy  : output - high while in RUN
//   oDone  : output - one-cycle pulse, oSum/oCout valid
//   oSum   : output - result register
//   oCout  : output - final carry-out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iCin,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oSum,
    output logic             oCout
);

    // One extra counter bit means the counter never wraps, even for WIDTH=1.
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_aSr;
    logic [WIDTH-1:0] r_bSr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_count;
    logic             w_faSum;
    logic             w_faCarry;

    FA u_fa (
        .iA (r_aSr[0]),
        .iB (r_bSr[0]),
        .iC (r_carry),
        .oS (w_faSum),
        .oC (w_faCarry)
    );

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. oBusy and oDone are decoded from the state
    // register only, so they have no combinational path from the inputs.
    always_comb begin
        w_nextState = r_state;
        oBusy       = 1'b0;
        oDone       = 1'b0;
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                oBusy = 1'b1;
                if (r_count == LAST_BIT) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                oDone       = 1'b1;
                w_nextState = iStart ? RUN : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath.
    // The sum bit enters oSum from the MSB end. After WIDTH shifts, the
    // first (LSB) result bit has landed in bit 0. Shifts are written so
    // that they also work for WIDTH=1.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_aSr   <= '0;
            r_bSr   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (iStart) begin
                        r_aSr   <= iA;
                        r_bSr   <= iB;
                        r_carry <= iCin;
                        r_count <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= (r_sum >> 1) | (WIDTH'(w_faSum) << (WIDTH - 1));
                    r_carry <= w_faCarry;
                    r_aSr   <= r_aSr >> 1;
                    r_bSr   <= r_bSr >> 1;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_BIT) begin
                        r_cout <= w_faCarry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oSum  = r_sum;
    assign oCout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// This is the self-checking bench for serial_adder with WIDTH=8.
// The reference result is plain integer addition of the operands and
// the carry-in. The bench also checks the busy window, the done latency,
// start-while-busy, reset in the middle of RUN, and back-to-back starts.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iStart;
    logic [W-1:0] iA;
    logic [W-1:0] iB;
    logic         iCin;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oSum;
    logic         oCout;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iA     (iA),
        .iB     (iB),
        .iCin   (iCin),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oSum   (oSum),
        .oCout  (oCout)
    );

    // 10-time-unit clock.
    always #5 iClk = ~iClk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] expSum;
        logic         expCout;
    } vec_t;

    vec_t vecs[6];

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Compare one value and count it.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue a start, then run until oDone is seen or the budget runs out.
    // Returns the edges counted from the accepted start to the first done
    // sample, the number of busy cycles, and oDone just after the start edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, output int edges,
                                 output int busyCycles, output logic doneAfterStart);
        iA     = a;
        iB     = b;
        iCin   = cin;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        // The operands may change freely once the start has been captured.
        iA   = W'($urandom);
        iB   = W'($urandom);
        iCin = 1'($urandom);
        edges          = 1;
        busyCycles     = 0;
        doneAfterStart = oDone;
        while (!oDone && edges < 40) begin
            if (oBusy) busyCycles++;
            step();
            edges++;
        end
    endtask

    // Run one addition and check its result against plain arithmetic.
    task automatic runAndCheck(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] expSum, input logic expCout);
        int   edges;
        int   busy;
        logic d0;
        applyStimulus(a, b, cin, edges, busy, d0);
        checkOutput({tag, " latency"}, edges, 9);
        checkOutput({tag, " busyCycles"}, busy, 8);
        checkOutput({tag, " doneAfterStart"}, d0, 0);
        checkOutput({tag, " busyAtDone"}, oBusy, 0);
        checkOutput({tag, " sum"}, oSum, expSum);
        checkOutput({tag, " cout"}, oCout, expCout);
    endtask

    initial begin
        int            edges;
        int            busy;
        int            doneCount;
        logic          d0;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          c;
        logic [W:0]    model;
        logic [W-1:0]  seenSum;
        logic          seenCout;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        iRst   = 1'b1;
        iStart = 1'b0;
        iA     = '0;
        iB     = '0;
        iCin   = 1'b0;
        step();
        step();
        checkOutput("reset busy", oBusy, 0);
        checkOutput("reset done", oDone, 0);
        checkOutput("reset sum", oSum, 0);
        checkOutput("reset cout", oCout, 0);
        iRst = 1'b0;
        step();

        // Table vectors. Each one returns to IDLE before the next start.
        for (int i = 0; i < 6; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                        vecs[i].expSum, vecs[i].expCout);
            step();
            checkOutput($sformatf("vec%0d donePulse", i), oDone, 0);
            checkOutput($sformatf("vec%0d sumHold", i), oSum, vecs[i].expSum);
        end

        // Randomized vectors against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            c     = 1'($urandom);
            model = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            runAndCheck($sformatf("rnd%0d", i), a, b, c, model[W-1:0], model[W]);
            step();
        end

        // A start while busy is ignored, and exactly one done pulse follows.
        iA = 8'h12; iB = 8'h34; iCin = 1'b0; iStart = 1'b1;
        step();
        iStart = 1'b0;
        step();
        step();
        iA = 8'hFF; iB = 8'hFF; iCin = 1'b1; iStart = 1'b1;
        step();
        iStart    = 1'b0;
        doneCount = 0;
        seenSum   = '0;
        seenCout  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (oDone) begin
                doneCount++;
                seenSum  = oSum;
                seenCout = oCout;
            end
            step();
        end
        checkOutput("ignoreStart doneCount", doneCount, 1);
        checkOutput("ignoreStart sum", seenSum, 8'h46);
        checkOutput("ignoreStart cout", seenCout, 0);

        // Reset in the middle of RUN discards the partial result.
        iA = 8'hAA; iB = 8'h55; iCin = 1'b0; iStart = 1'b1;
        step();
        iStart = 1'b0;
        step();
        step();
        step();
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        checkOutput("midReset busy", oBusy, 0);
        checkOutput("midReset done", oDone, 0);
        checkOutput("midReset sum", oSum, 0);
        checkOutput("midReset cout", oCout, 0);
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            if (oDone) doneCount++;
            step();
        end
        checkOutput("midReset noDone", doneCount, 0);
        runAndCheck("afterReset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        step();

        // Back-to-back: the second start is issued during the DONE cycle.
        runAndCheck("b2b first", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0, edges, busy, d0);
        checkOutput("b2b firstDoneOneCycle", d0, 0);
        checkOutput("b2b latency", edges, 9);
        checkOutput("b2b busyCycles", busy, 8);
        checkOutput("b2b sum", oSum, 8'h00);
        checkOutput("b2b cout", oCout, 1);
        step();
        checkOutput("b2b idle", oDone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
